// File: rtl/idex_stage_reg_if.sv
// ============================================================================
// Module  : idex_stage_reg_if
// Brief   : ID-side inputs and ID/EX registered outputs of the ID/EX stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface idex_stage_reg_if;
  // ID-stage inputs
  logic [4:0]  IFID_rs1;
  logic [4:0]  IFID_rs2;
  logic [4:0]  IFID_rd;
  logic [31:0] IFID_pc;
  logic [31:0] IFID_imm;
  logic [31:0] ID_rdata1;
  logic [31:0] ID_rdata2;
  logic [7:0]  ID_ctrl;
  logic        IFID_valid;
  logic        EX_flush;

  // ID/EX registered outputs
  logic [4:0]  IDEX_rs1;
  logic [4:0]  IDEX_rs2;
  logic [4:0]  IDEX_rd;
  logic [31:0] IDEX_pc;
  logic [31:0] IDEX_imm;
  logic [31:0] IDEX_rdata1;
  logic [31:0] IDEX_rdata2;
  logic [7:0]  IDEX_ctrl;
  logic        IDEX_valid;
  logic        stall;

  // Decode side drives the ID signals and observes the register contents
  modport master (
    output IFID_rs1, IFID_rs2, IFID_rd, IFID_pc, IFID_imm,
           ID_rdata1, ID_rdata2, ID_ctrl, IFID_valid, EX_flush,
    input  IDEX_rs1, IDEX_rs2, IDEX_rd, IDEX_pc, IDEX_imm,
           IDEX_rdata1, IDEX_rdata2, IDEX_ctrl, IDEX_valid, stall
  );

  // The stage register itself
  modport slave (
    input  IFID_rs1, IFID_rs2, IFID_rd, IFID_pc, IFID_imm,
           ID_rdata1, ID_rdata2, ID_ctrl, IFID_valid, EX_flush,
    output IDEX_rs1, IDEX_rs2, IDEX_rd, IDEX_pc, IDEX_imm,
           IDEX_rdata1, IDEX_rdata2, IDEX_ctrl, IDEX_valid, stall
  );
endinterface

`default_nettype wire

// File: rtl/idex_stage_reg.sv
// ============================================================================
// Module  : idex_stage_reg
// Brief   : ID/EX pipeline register with load-use stall and flush bubbling.
//           Optional event counters enabled by macro IDEX_PERF_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module idex_stage_reg (
  input  wire                clk,
  input  wire                rst_n,
  idex_stage_reg_if.slave    bus
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [15:0]        stall_count,
  output logic [15:0]        flush_count
`endif
);

  localparam int unsigned C_MEMREAD_BIT = 6;

  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [4:0]  r_rd;
  logic [31:0] r_pc;
  logic [31:0] r_imm;
  logic [31:0] r_rdata1;
  logic [31:0] r_rdata2;
  logic [7:0]  r_ctrl;
  logic        r_valid;

  logic        w_rd_match;
  logic        w_stall;
  logic        w_bubble;

  // A load in EX whose destination is read by the ID instruction must wait a cycle.
  // A flush kills the ID instruction, so there is nothing left to stall for.
  assign w_rd_match = (r_rd == bus.IFID_rs1) || (r_rd == bus.IFID_rs2);
  assign w_stall    = r_valid && r_ctrl[C_MEMREAD_BIT] && (r_rd != 5'd0) &&
                      w_rd_match && bus.IFID_valid && !bus.EX_flush;
  assign w_bubble   = bus.EX_flush || w_stall || !bus.IFID_valid;

  // Data fields always follow the inputs; only control, rd and valid are squashed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs1    <= 5'd0;
      r_rs2    <= 5'd0;
      r_rd     <= 5'd0;
      r_pc     <= 32'd0;
      r_imm    <= 32'd0;
      r_rdata1 <= 32'd0;
      r_rdata2 <= 32'd0;
      r_ctrl   <= 8'd0;
      r_valid  <= 1'b0;
    end else begin
      r_rs1    <= bus.IFID_rs1;
      r_rs2    <= bus.IFID_rs2;
      r_pc     <= bus.IFID_pc;
      r_imm    <= bus.IFID_imm;
      r_rdata1 <= bus.ID_rdata1;
      r_rdata2 <= bus.ID_rdata2;
      if (w_bubble) begin
        r_rd    <= 5'd0;
        r_ctrl  <= 8'd0;
        r_valid <= 1'b0;
      end else begin
        r_rd    <= bus.IFID_rd;
        r_ctrl  <= bus.ID_ctrl;
        r_valid <= 1'b1;
      end
    end
  end

  assign bus.IDEX_rs1    = r_rs1;
  assign bus.IDEX_rs2    = r_rs2;
  assign bus.IDEX_rd     = r_rd;
  assign bus.IDEX_pc     = r_pc;
  assign bus.IDEX_imm    = r_imm;
  assign bus.IDEX_rdata1 = r_rdata1;
  assign bus.IDEX_rdata2 = r_rdata2;
  assign bus.IDEX_ctrl   = r_ctrl;
  assign bus.IDEX_valid  = r_valid;
  assign bus.stall       = w_stall;

`ifdef IDEX_PERF_CNT_EN
  localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

  logic [15:0] r_stall_count;
  logic [15:0] r_flush_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= 16'd0;
      r_flush_count <= 16'd0;
    end else begin
      if (w_stall && (r_stall_count != C_CNT_MAX)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
      if (bus.EX_flush && (r_flush_count != C_CNT_MAX)) begin
        r_flush_count <= r_flush_count + 16'd1;
      end
    end
  end

  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_idex_stage_reg.sv
// ============================================================================
// Module  : tb_idex_stage_reg
// Brief   : Directed self-checking bench for the ID/EX stage register.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_idex_stage_reg;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  idex_stage_reg_if bus();

`ifdef IDEX_PERF_CNT_EN
  logic [15:0] stall_count;
  logic [15:0] flush_count;
`endif

  idex_stage_reg dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus)
`ifdef IDEX_PERF_CNT_EN
    ,
    .stall_count (stall_count),
    .flush_count (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_id(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [7:0] ctrl,
                          input logic valid, input logic flush,
                          input logic [31:0] pc);
    bus.IFID_rs1   = rs1;
    bus.IFID_rs2   = rs2;
    bus.IFID_rd    = rd;
    bus.ID_ctrl    = ctrl;
    bus.IFID_valid = valid;
    bus.EX_flush   = flush;
    bus.IFID_pc    = pc;
    bus.IFID_imm   = pc ^ 32'hFFFF_0000;
    bus.ID_rdata1  = pc + 32'h0000_0011;
    bus.ID_rdata2  = pc + 32'h0000_0022;
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_id(5'd0, 5'd0, 5'd0, 8'h00, 1'b0, 1'b0, 32'd0);
    #3;
    checks++;
    if (bus.IDEX_valid !== 1'b0 || bus.IDEX_ctrl !== 8'h00 || bus.IDEX_rd !== 5'd0 ||
        bus.IDEX_pc !== 32'd0 || bus.IDEX_rdata1 !== 32'd0 || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b ctrl=%h rd=%0d pc=%h stall=%b, expected all 0",
               bus.IDEX_valid, bus.IDEX_ctrl, bus.IDEX_rd, bus.IDEX_pc, bus.stall);
    end
`ifdef IDEX_PERF_CNT_EN
    checks++;
    if (stall_count !== 16'd0 || flush_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters: stall_count=%h flush_count=%h, expected 0",
               stall_count, flush_count);
    end
`endif
    step();
    rst_n = 1'b1;

    // Mid-cycle asynchronous reset while a valid instruction is held.
    drive_id(5'd1, 5'd2, 5'd6, 8'h82, 1'b1, 1'b0, 32'h0000_0400);
    step();
    checks++;
    if (bus.IDEX_valid !== 1'b1 || bus.IDEX_rd !== 5'd6) begin
      errors++;
      $display("FAIL reset_preload: valid=%b rd=%0d, expected valid=1 rd=6",
               bus.IDEX_valid, bus.IDEX_rd);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.IDEX_valid !== 1'b0 || bus.IDEX_ctrl !== 8'h00 || bus.IDEX_rd !== 5'd0 ||
        bus.IDEX_rs1 !== 5'd0 || bus.IDEX_pc !== 32'd0 || bus.IDEX_imm !== 32'd0 ||
        bus.IDEX_rdata2 !== 32'd0) begin
      errors++;
      $display("FAIL reset_async: valid=%b ctrl=%h rd=%0d rs1=%0d pc=%h imm=%h, expected all 0",
               bus.IDEX_valid, bus.IDEX_ctrl, bus.IDEX_rd, bus.IDEX_rs1,
               bus.IDEX_pc, bus.IDEX_imm);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.IDEX_valid !== 1'b1 || bus.IDEX_ctrl !== 8'h82 || bus.IDEX_pc !== 32'h0000_0400) begin
      errors++;
      $display("FAIL reset_release_load: valid=%b ctrl=%h pc=%h, expected 1 82 00000400",
               bus.IDEX_valid, bus.IDEX_ctrl, bus.IDEX_pc);
    end
  endtask

  task automatic test_pass_through();
    drive_id(5'd3, 5'd4, 5'd5, 8'h83, 1'b1, 1'b0, 32'h0000_1000);
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL pass_stall: stall=%b, expected 0", bus.stall);
    end
    step();
    checks++;
    if (bus.IDEX_rs1 !== 5'd3 || bus.IDEX_rs2 !== 5'd4 || bus.IDEX_rd !== 5'd5 ||
        bus.IDEX_ctrl !== 8'h83 || bus.IDEX_valid !== 1'b1) begin
      errors++;
      $display("FAIL pass_fields: rs1=%0d rs2=%0d rd=%0d ctrl=%h valid=%b, expected 3 4 5 83 1",
               bus.IDEX_rs1, bus.IDEX_rs2, bus.IDEX_rd, bus.IDEX_ctrl, bus.IDEX_valid);
    end
    checks++;
    if (bus.IDEX_pc !== 32'h0000_1000 || bus.IDEX_imm !== 32'hFFFF_1000 ||
        bus.IDEX_rdata1 !== 32'h0000_1011 || bus.IDEX_rdata2 !== 32'h0000_1022) begin
      errors++;
      $display("FAIL pass_data: pc=%h imm=%h rd1=%h rd2=%h, expected 00001000 ffff1000 00001011 00001022",
               bus.IDEX_pc, bus.IDEX_imm, bus.IDEX_rdata1, bus.IDEX_rdata2);
    end
  endtask

  task automatic test_load_use();
    drive_id(5'd2, 5'd3, 5'd7, 8'hD0, 1'b1, 1'b0, 32'h0000_1100);
    step();
    drive_id(5'd1, 5'd7, 5'd9, 8'h82, 1'b1, 1'b0, 32'h0000_2000);
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin
      errors++;
      $display("FAIL loaduse_stall: stall=%b, expected 1", bus.stall);
    end
    step();
    checks++;
    if (bus.IDEX_ctrl !== 8'h00 || bus.IDEX_rd !== 5'd0 || bus.IDEX_valid !== 1'b0 ||
        bus.IDEX_pc !== 32'h0000_2000 || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL loaduse_bubble: ctrl=%h rd=%0d valid=%b pc=%h stall=%b, expected 00 0 0 00002000 0",
               bus.IDEX_ctrl, bus.IDEX_rd, bus.IDEX_valid, bus.IDEX_pc, bus.stall);
    end
    step();
    checks++;
    if (bus.IDEX_rd !== 5'd9 || bus.IDEX_ctrl !== 8'h82 || bus.IDEX_valid !== 1'b1) begin
      errors++;
      $display("FAIL loaduse_consumer: rd=%0d ctrl=%h valid=%b, expected 9 82 1",
               bus.IDEX_rd, bus.IDEX_ctrl, bus.IDEX_valid);
    end
  endtask

  task automatic test_x0_load();
    drive_id(5'd4, 5'd5, 5'd0, 8'hD0, 1'b1, 1'b0, 32'h0000_3000);
    step();
    checks++;
    if (bus.IDEX_rd !== 5'd0 || bus.IDEX_ctrl !== 8'hD0 || bus.IDEX_valid !== 1'b1) begin
      errors++;
      $display("FAIL x0_passthrough: rd=%0d ctrl=%h valid=%b, expected 0 d0 1",
               bus.IDEX_rd, bus.IDEX_ctrl, bus.IDEX_valid);
    end
    drive_id(5'd0, 5'd0, 5'd8, 8'h82, 1'b1, 1'b0, 32'h0000_3004);
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL x0_stall: stall=%b, expected 0", bus.stall);
    end
    step();
  endtask

  task automatic test_flush_vs_stall();
`ifdef IDEX_PERF_CNT_EN
    logic [15:0] sc0;
    logic [15:0] fc0;
`endif
    drive_id(5'd2, 5'd3, 5'd7, 8'hD0, 1'b1, 1'b0, 32'h0000_4000);
    step();
`ifdef IDEX_PERF_CNT_EN
    sc0 = stall_count;
    fc0 = flush_count;
`endif
    drive_id(5'd7, 5'd1, 5'd10, 8'h82, 1'b1, 1'b1, 32'h0000_4004);
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: stall=%b, expected 0", bus.stall);
    end
    step();
    checks++;
    if (bus.IDEX_ctrl !== 8'h00 || bus.IDEX_rd !== 5'd0 || bus.IDEX_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_bubble: ctrl=%h rd=%0d valid=%b, expected 00 0 0",
               bus.IDEX_ctrl, bus.IDEX_rd, bus.IDEX_valid);
    end
`ifdef IDEX_PERF_CNT_EN
    checks++;
    if (flush_count !== fc0 + 16'd1 || stall_count !== sc0) begin
      errors++;
      $display("FAIL flush_counters: stall_count=%h flush_count=%h, expected %h %h",
               stall_count, flush_count, sc0, fc0 + 16'd1);
    end
`endif
    bus.EX_flush = 1'b0;
  endtask

  task automatic test_invalid();
`ifdef IDEX_PERF_CNT_EN
    logic [15:0] fc0;
`endif
    drive_id(5'd11, 5'd12, 5'd13, 8'hFF, 1'b0, 1'b0, 32'h0000_5000);
    step();
    checks++;
    if (bus.IDEX_ctrl !== 8'h00 || bus.IDEX_valid !== 1'b0 || bus.IDEX_pc !== 32'h0000_5000) begin
      errors++;
      $display("FAIL invalid_bubble: ctrl=%h valid=%b pc=%h, expected 00 0 00005000",
               bus.IDEX_ctrl, bus.IDEX_valid, bus.IDEX_pc);
    end
`ifdef IDEX_PERF_CNT_EN
    fc0 = flush_count;
`endif
    drive_id(5'd11, 5'd12, 5'd13, 8'hFF, 1'b0, 1'b1, 32'h0000_5004);
    step();
    bus.EX_flush = 1'b0;
    checks++;
    if (bus.IDEX_ctrl !== 8'h00 || bus.IDEX_valid !== 1'b0 || bus.IDEX_rd !== 5'd0) begin
      errors++;
      $display("FAIL flush_invalid_bubble: ctrl=%h valid=%b rd=%0d, expected 00 0 0",
               bus.IDEX_ctrl, bus.IDEX_valid, bus.IDEX_rd);
    end
`ifdef IDEX_PERF_CNT_EN
    checks++;
    if (flush_count !== fc0 + 16'd1) begin
      errors++;
      $display("FAIL flush_invalid_count: flush_count=%h, expected %h",
               flush_count, fc0 + 16'd1);
    end
`endif
  endtask

`ifdef IDEX_PERF_CNT_EN
  task automatic one_stall();
    drive_id(5'd2, 5'd3, 5'd7, 8'hD0, 1'b1, 1'b0, 32'h0000_6000);
    step();
    drive_id(5'd7, 5'd0, 5'd9, 8'h82, 1'b1, 1'b0, 32'h0000_6004);
    step();
  endtask

  task automatic test_saturation();
    dut.r_stall_count <= 16'hFFFC;
    #1;
    one_stall();
    one_stall();
    checks++;
    if (stall_count !== 16'hFFFE) begin
      errors++;
      $display("FAIL sat_preload: stall_count=%h, expected fffe", stall_count);
    end
    one_stall();
    one_stall();
    one_stall();
    checks++;
    if (stall_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_hold: stall_count=%h, expected ffff", stall_count);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_pass_through();
    test_load_use();
    test_x0_load();
    test_flush_vs_stall();
    test_invalid();
`ifdef IDEX_PERF_CNT_EN
    test_saturation();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
